// File: rtl/sim_status_pkg.sv
// Shared types for the sim status TL-UL host: minimal TL-UL channel structs,
// status code values, host FSM states and a terminal-code helper.
package sim_status_pkg;

  localparam int unsigned TL_AW  = 32;
  localparam int unsigned TL_DW  = 32;
  localparam int unsigned TL_AIW = 8;
  localparam int unsigned TL_DIW = 1;
  localparam int unsigned TL_DBW = TL_DW / 8;
  localparam int unsigned TL_SZW = 2;

  localparam logic [15:0] StatusInTest = 16'h4354;
  localparam logic [15:0] StatusPassed = 16'h900d;
  localparam logic [15:0] StatusFailed = 16'hbaad;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [4:0] rsvd;
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  // Data access (instr_type = false encoding), no integrity generated in sim.
  localparam tl_a_user_t TL_A_USER_DEFAULT = '{
    rsvd:       '0,
    instr_type: 4'h9,
    cmd_intg:   '0,
    data_intg:  '0
  };

  typedef struct packed {
    logic                a_valid;
    tl_a_op_e            a_opcode;
    logic [2:0]          a_param;
    logic [TL_SZW-1:0]   a_size;
    logic [TL_AIW-1:0]   a_source;
    logic [TL_AW-1:0]    a_address;
    logic [TL_DBW-1:0]   a_mask;
    logic [TL_DW-1:0]    a_data;
    tl_a_user_t          a_user;
    logic                d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                d_valid;
    tl_d_op_e            d_opcode;
    logic [2:0]          d_param;
    logic [TL_SZW-1:0]   d_size;
    logic [TL_AIW-1:0]   d_source;
    logic [TL_DIW-1:0]   d_sink;
    logic [TL_DW-1:0]    d_data;
    tl_d_user_t          d_user;
    logic                d_error;
    logic                a_ready;
  } tl_d2h_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StRsp  = 2'd2
  } state_e;

  function automatic logic is_terminal(input logic [15:0] code);
    return (code == StatusPassed) || (code == StatusFailed);
  endfunction

endpackage

// File: rtl/sim_status_tl_host_fifo.sv
// Small synchronous FIFO holding queued status codes.
module sim_status_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push,
  input  logic [Width-1:0]             wdata,
  input  logic                         pop,
  output logic [Width-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(Depth+1)-1:0]   count
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CntFull);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy tracking; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  // Storage array, no reset needed since reads are qualified by empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/sim_status_tl_host.sv
// TL-UL host that writes queued SW test status codes to the sim SRAM status
// word, letting a bench end or annotate a simulation without a running core.
module sim_status_tl_host
  import sim_status_pkg::*;
#(
  parameter logic [31:0] StatusAddr    = 32'h0,
  parameter int unsigned Depth         = 2,
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned SourceW       = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        status_valid_i,
  output logic        status_ready_o,
  input  logic [15:0] status_code_i,
  output tl_h2d_t     tl_o,
  input  tl_d2h_t     tl_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] last_code_o
);

  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);
  localparam logic [TmoW-1:0] TmoMax  = TmoW'(TimeoutCycles);

  state_e               state_q;
  logic [15:0]          code_q;
  logic [SourceW-1:0]   src_q;
  logic [TmoW-1:0]      tmo_q;
  logic                 done_q;
  logic                 err_q;
  logic [15:0]          last_q;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [15:0]          fifo_rdata;
  logic [$clog2(Depth+1)-1:0] fifo_count;

  logic                 tmo_hit;
  logic                 rsp_bad;
  logic                 unused_tl;

  assign status_ready_o = !fifo_full && !done_q;
  assign fifo_push      = status_valid_i && status_ready_o;
  assign fifo_pop       = (state_q == StIdle) && !fifo_empty;

  sim_status_fifo #(
    .Width (16),
    .Depth (Depth)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (fifo_push),
    .wdata (status_code_i),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // The final permitted cycle is the one where the counter sits at TimeoutCycles-1;
  // a handshake in that same cycle still wins over the abort.
  assign tmo_hit = (tmo_q >= TmoLast);
  assign rsp_bad = tl_i.d_error || (tl_i.d_source != TL_AIW'(src_q));

  // Host FSM with timeout, rolling source id and sticky status flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      code_q  <= '0;
      src_q   <= '0;
      tmo_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= '0;
    end else begin
      if ((state_q != StIdle) && (tmo_q != TmoMax)) tmo_q <= tmo_q + 1'b1;
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            code_q  <= fifo_rdata;
            tmo_q   <= '0;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (tl_i.a_ready) begin
            state_q <= StRsp;
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            src_q   <= src_q + 1'b1;
            state_q <= StIdle;
          end
        end
        StRsp: begin
          if (tl_i.d_valid) begin
            if (rsp_bad) begin
              err_q <= 1'b1;
            end else begin
              last_q <= code_q;
              if (is_terminal(code_q)) done_q <= 1'b1;
            end
            src_q   <= src_q + 1'b1;
            state_q <= StIdle;
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            src_q   <= src_q + 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // A-channel fields are derived only from registered state, so they hold
  // steady for as long as a_valid waits on a_ready.
  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = (state_q == StReq);
    tl_o.a_opcode  = PutFullData;
    tl_o.a_param   = '0;
    tl_o.a_size    = TL_SZW'(2);
    tl_o.a_source  = TL_AIW'(src_q);
    tl_o.a_address = StatusAddr;
    tl_o.a_mask    = '1;
    tl_o.a_data    = {16'h0, code_q};
    tl_o.a_user    = TL_A_USER_DEFAULT;
    tl_o.d_ready   = (state_q == StRsp);
  end

  assign busy_o      = !fifo_empty || (state_q != StIdle);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign last_code_o = last_q;

  assign unused_tl = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_sink,
                       tl_i.d_data, tl_i.d_user, fifo_count};

endmodule

// File: tb/tb_sim_status_tl_host.sv
// Directed self-checking bench for sim_status_tl_host acting as a hand-driven responder.
module tb_sim_status_tl_host;
  import sim_status_pkg::*;

  localparam logic [31:0] Addr = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        status_valid = 1'b0;
  logic [15:0] status_code = '0;
  logic        status_ready;
  logic        busy, done, err;
  logic [15:0] last_code;
  tl_h2d_t     tl_o;
  tl_d2h_t     tl_i;

  logic              a_ready  = 1'b1;
  logic              d_valid  = 1'b0;
  logic              d_error  = 1'b0;
  logic [TL_AIW-1:0] d_source = '0;

  int checks = 0;
  int errors = 0;
  int a_hs   = 0;

  sim_status_tl_host #(
    .StatusAddr    (Addr),
    .Depth         (2),
    .TimeoutCycles (16),
    .SourceW       (2)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .status_valid_i (status_valid),
    .status_ready_o (status_ready),
    .status_code_i  (status_code),
    .tl_o           (tl_o),
    .tl_i           (tl_i),
    .busy_o         (busy),
    .done_o         (done),
    .err_o          (err),
    .last_code_o    (last_code)
  );

  always #5 clk = ~clk;

  // Responder driven from bench variables.
  always_comb begin
    tl_i          = '0;
    tl_i.d_valid  = d_valid;
    tl_i.d_opcode = AccessAck;
    tl_i.d_size   = 2'd2;
    tl_i.d_source = d_source;
    tl_i.d_error  = d_error;
    tl_i.a_ready  = a_ready;
  end

  // Count accepted A-channel beats.
  always @(posedge clk) begin
    if (tl_o.a_valid && tl_i.a_ready) a_hs <= a_hs + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    status_valid = 1'b0;
    d_valid = 1'b0;
    d_error = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push_one(input logic [15:0] code);
    status_valid = 1'b1;
    status_code  = code;
    tick();
    status_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    do_reset();
    check("rst_a_valid", 32'(tl_o.a_valid), 0);
    check("rst_d_ready", 32'(tl_o.d_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_last", 32'(last_code), 0);
    check("rst_ready", 32'(status_ready), 1);

    // Single IN_TEST write, zero-latency responder
    a_ready = 1'b1;
    push_one(16'h4354);
    check("t1_busy_queued", 32'(busy), 1);
    tick();
    check("t1_a_valid", 32'(tl_o.a_valid), 1);
    check("t1_opcode", 32'(tl_o.a_opcode), 0);
    check("t1_param", 32'(tl_o.a_param), 0);
    check("t1_size", 32'(tl_o.a_size), 2);
    check("t1_mask", 32'(tl_o.a_mask), 32'hf);
    check("t1_addr", tl_o.a_address, Addr);
    check("t1_data", tl_o.a_data, 32'h0000_4354);
    check("t1_source", 32'(tl_o.a_source), 0);
    tick();
    check("t1_rsp_a_valid", 32'(tl_o.a_valid), 0);
    check("t1_rsp_d_ready", 32'(tl_o.d_ready), 1);
    d_valid = 1'b1;
    d_source = 8'd0;
    tick();
    d_valid = 1'b0;
    check("t1_last", 32'(last_code), 32'h4354);
    check("t1_done", 32'(done), 0);
    check("t1_err", 32'(err), 0);
    check("t1_busy_end", 32'(busy), 0);
    check("t1_hs", a_hs, 1);

    // Back-to-back IN_TEST then PASSED
    do_reset();
    status_valid = 1'b1;
    status_code  = 16'h4354;
    check("t2_ready0", 32'(status_ready), 1);
    tick();
    status_code = 16'h900d;
    check("t2_ready1", 32'(status_ready), 1);
    tick();
    status_valid = 1'b0;
    check("t2_w0_data", tl_o.a_data, 32'h0000_4354);
    check("t2_w0_src", 32'(tl_o.a_source), 0);
    tick();
    d_valid = 1'b1;
    d_source = 8'd0;
    tick();
    d_valid = 1'b0;
    check("t2_last0", 32'(last_code), 32'h4354);
    check("t2_done0", 32'(done), 0);
    tick();
    check("t2_w1_valid", 32'(tl_o.a_valid), 1);
    check("t2_w1_data", tl_o.a_data, 32'h0000_900d);
    check("t2_w1_src", 32'(tl_o.a_source), 1);
    tick();
    d_valid = 1'b1;
    d_source = 8'd1;
    tick();
    d_valid = 1'b0;
    check("t2_last1", 32'(last_code), 32'h900d);
    check("t2_done1", 32'(done), 1);
    check("t2_ready_after_done", 32'(status_ready), 0);
    check("t2_busy", 32'(busy), 0);
    check("t2_hs", a_hs, 3);

    // A channel stalled by a_ready=0 for 5 cycles
    do_reset();
    a_ready = 1'b0;
    push_one(16'h4354);
    tick();
    check("t3_a_valid0", 32'(tl_o.a_valid), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_stall_valid", 32'(tl_o.a_valid), 1);
      check("t3_stall_addr", tl_o.a_address, Addr);
      check("t3_stall_data", tl_o.a_data, 32'h0000_4354);
      check("t3_stall_src", 32'(tl_o.a_source), 0);
      check("t3_stall_hs", a_hs, 3);
    end
    a_ready = 1'b1;
    tick();
    check("t3_rsp_a_valid", 32'(tl_o.a_valid), 0);
    check("t3_rsp_d_ready", 32'(tl_o.d_ready), 1);
    d_valid = 1'b1;
    d_source = 8'd0;
    tick();
    d_valid = 1'b0;
    check("t3_last", 32'(last_code), 32'h4354);
    check("t3_busy", 32'(busy), 0);
    check("t3_hs", a_hs, 4);

    // Responder never answers: timeout, then next queued code still sent
    status_valid = 1'b1;
    status_code  = 16'h1234;
    tick();
    status_code = 16'h5678;
    tick();
    status_valid = 1'b0;
    check("t4_a_rise", 32'(tl_o.a_valid), 1);
    check("t4_a_src", 32'(tl_o.a_source), 1);
    for (int i = 0; i < 15; i++) begin
      tick();
      check("t4_wait_err", 32'(err), 0);
      check("t4_wait_d_ready", 32'(tl_o.d_ready), 1);
    end
    tick();
    check("t4_tmo_err", 32'(err), 1);
    check("t4_tmo_d_ready", 32'(tl_o.d_ready), 0);
    check("t4_tmo_a_valid", 32'(tl_o.a_valid), 0);
    check("t4_tmo_last", 32'(last_code), 32'h4354);
    tick();
    check("t4_next_valid", 32'(tl_o.a_valid), 1);
    check("t4_next_data", tl_o.a_data, 32'h0000_5678);
    check("t4_next_src", 32'(tl_o.a_source), 2);
    tick();
    d_valid = 1'b1;
    d_source = 8'd2;
    tick();
    d_valid = 1'b0;
    check("t4_last", 32'(last_code), 32'h5678);
    check("t4_done", 32'(done), 0);
    check("t4_hs", a_hs, 6);

    // d_error response
    do_reset();
    push_one(16'h1111);
    tick();
    tick();
    d_valid = 1'b1;
    d_error = 1'b1;
    d_source = 8'd0;
    tick();
    d_valid = 1'b0;
    d_error = 1'b0;
    check("t5_derr_err", 32'(err), 1);
    check("t5_derr_last", 32'(last_code), 0);
    check("t5_derr_busy", 32'(busy), 0);

    // Wrong d_source response
    do_reset();
    push_one(16'h2222);
    tick();
    tick();
    d_valid = 1'b1;
    d_source = 8'd1;
    tick();
    d_valid = 1'b0;
    check("t5_src_err", 32'(err), 1);
    check("t5_src_last", 32'(last_code), 0);

    // Reset during RSP
    push_one(16'h3333);
    tick();
    tick();
    check("t6_in_rsp", 32'(tl_o.d_ready), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_a_valid", 32'(tl_o.a_valid), 0);
    check("t6_d_ready", 32'(tl_o.d_ready), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_err", 32'(err), 0);
    check("t6_done", 32'(done), 0);
    check("t6_src", 32'(tl_o.a_source), 0);
    check("t6_ready", 32'(status_ready), 1);

    // Fill FIFO to Depth while the FSM is stalled
    a_ready = 1'b0;
    status_valid = 1'b1;
    status_code  = 16'h0101;
    tick();
    status_code = 16'h0202;
    check("t6_fill_ready1", 32'(status_ready), 1);
    tick();
    status_code = 16'h0303;
    check("t6_fill_ready2", 32'(status_ready), 1);
    tick();
    status_code = 16'h0404;
    check("t6_full_ready", 32'(status_ready), 0);
    tick();
    check("t6_full_ready_hold", 32'(status_ready), 0);
    check("t6_full_a_valid", 32'(tl_o.a_valid), 1);
    a_ready = 1'b1;
    tick();
    check("t6_full_rsp_ready", 32'(status_ready), 0);
    d_valid = 1'b1;
    d_source = 8'd0;
    tick();
    d_valid = 1'b0;
    check("t6_full_ack_ready", 32'(status_ready), 0);
    check("t6_full_last", 32'(last_code), 32'h0101);
    tick();
    check("t6_after_pop_ready", 32'(status_ready), 1);
    check("t6_after_pop_data", tl_o.a_data, 32'h0000_0202);
    status_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
